tx_bf_ch: RTL



---
 rtl/tx_bf_ch_pkg.sv | 26 ++
 rtl/tx_bf_ch_lut.sv | 27 ++
 rtl/tx_bf_ch.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tx_bf_ch_pkg.sv
// Shared widths, defaults and state encoding for the transmit beamforming channel.
package tx_bf_ch_pkg;

  localparam int ADDR_WD_DEF     = 8;
  localparam int DELAY_WD_DEF    = 12;
  localparam int HP_WD_DEF       = 6;
  localparam int NC_WD_DEF       = 4;
  localparam int DAMP_CYCLES_DEF = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DELAY = 3'd2;
  localparam logic [2:0] ST_FIRE  = 3'd3;
  localparam logic [2:0] ST_DAMP  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_DELAY = ST_DELAY,
    S_FIRE  = ST_FIRE,
    S_DAMP  = ST_DAMP,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/tx_bf_ch_lut.sv
// Per-line transmit delay table: simple dual-port RAM, registered read-first output.
module tx_delay_lut
  import tx_bf_ch_pkg::*;
#(
  parameter int ADDR_WD  = ADDR_WD_DEF,
  parameter int DELAY_WD = DELAY_WD_DEF
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_WD-1:0]  waddr,
  input  logic [DELAY_WD-1:0] wdata,
  input  logic [ADDR_WD-1:0]  raddr,
  output logic [DELAY_WD-1:0] rdata
);

  logic [DELAY_WD-1:0] mem [2**ADDR_WD];
  logic [DELAY_WD-1:0] rdata_q;

  // Read and write in one block so a same-address collision returns old data.
  always_ff @(posedge clk) begin
    rdata_q <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tx_bf_ch.sv
// Transmit beamforming channel: fetch per-line delay, wait, fire bipolar burst, clamp.
module tx_bf_ch
  import tx_bf_ch_pkg::*;
#(
  parameter int ADDR_WD     = ADDR_WD_DEF,
  parameter int DELAY_WD    = DELAY_WD_DEF,
  parameter int HP_WD       = HP_WD_DEF,
  parameter int NC_WD       = NC_WD_DEF,
  parameter int DAMP_CYCLES = DAMP_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_WD-1:0]  lut_addr,
  input  logic                lut_we,
  input  logic [DELAY_WD-1:0] lut_din,
  input  logic                start,
  input  logic [ADDR_WD-1:0]  line_addr,
  input  logic [HP_WD-1:0]    half_period,
  input  logic [NC_WD-1:0]    num_cycles,
  output logic                pulse_p,
  output logic                pulse_n,
  output logic                clamp,
  output logic                tx_en,
  output logic                busy,
  output logic                done
);

  localparam int DW = $clog2(DAMP_CYCLES + 1);

  state_t              state_q, state_d;
  logic [ADDR_WD-1:0]  line_q, line_d;
  logic [HP_WD-1:0]    hp_q, hp_d, ph_q, ph_d;
  logic [NC_WD-1:0]    nc_q, nc_d, cyc_q, cyc_d;
  logic                neg_q, neg_d, first_q, first_d;
  logic [DELAY_WD-1:0] cnt_q, cnt_d, cnt_cur, lut_rdata;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic                pulse_p_q, pulse_p_d, pulse_n_q, pulse_n_d, clamp_q, clamp_d;
  logic                tx_en_q, tx_en_d, done_q, done_d;

  tx_delay_lut #(.ADDR_WD(ADDR_WD), .DELAY_WD(DELAY_WD)) u_lut (
    .clk   (clk),
    .we    (lut_we),
    .waddr (lut_addr),
    .wdata (lut_din),
    .raddr (line_q),
    .rdata (lut_rdata)
  );

  // On the first DELAY cycle the freshly read LUT word stands in for the counter.
  assign cnt_cur = first_q ? lut_rdata : cnt_q;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    hp_d    = hp_q;
    nc_d    = nc_q;
    ph_d    = ph_q;
    cyc_d   = cyc_q;
    neg_d   = neg_q;
    first_d = 1'b0;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          line_d  = line_addr;
          hp_d    = (half_period == '0) ? HP_WD'(1) : half_period;
          nc_d    = num_cycles;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        first_d = 1'b1;
        state_d = S_DELAY;
      end
      S_DELAY: begin
        if (cnt_cur == '0) begin
          ph_d    = '0;
          neg_d   = 1'b0;
          cyc_d   = '0;
          dcnt_d  = '0;
          state_d = (nc_q == '0) ? S_DAMP : S_FIRE;
        end else begin
          cnt_d = cnt_cur - DELAY_WD'(1);
        end
      end
      S_FIRE: begin
        if (ph_q == hp_q - HP_WD'(1)) begin
          ph_d = '0;
          if (neg_q) begin
            neg_d = 1'b0;
            if (cyc_q == nc_q - NC_WD'(1)) begin
              dcnt_d  = '0;
              state_d = S_DAMP;
            end else begin
              cyc_d = cyc_q + NC_WD'(1);
            end
          end else begin
            neg_d = 1'b1;
          end
        end else begin
          ph_d = ph_q + HP_WD'(1);
        end
      end
      S_DAMP: begin
        if (dcnt_q == DW'(DAMP_CYCLES - 1)) state_d = S_DONE;
        else                                dcnt_d  = dcnt_q + DW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    pulse_p_d = (state_d == S_FIRE) && !neg_d;
    pulse_n_d = (state_d == S_FIRE) && neg_d;
    clamp_d   = (state_d == S_DAMP);
    tx_en_d   = (state_d == S_FETCH) || (state_d == S_DELAY) ||
                (state_d == S_FIRE)  || (state_d == S_DAMP);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      line_q    <= '0;
      hp_q      <= '0;
      nc_q      <= '0;
      ph_q      <= '0;
      cyc_q     <= '0;
      neg_q     <= 1'b0;
      first_q   <= 1'b0;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      pulse_p_q <= 1'b0;
      pulse_n_q <= 1'b0;
      clamp_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      hp_q      <= hp_d;
      nc_q      <= nc_d;
      ph_q      <= ph_d;
      cyc_q     <= cyc_d;
      neg_q     <= neg_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      pulse_p_q <= pulse_p_d;
      pulse_n_q <= pulse_n_d;
      clamp_q   <= clamp_d;
      tx_en_q   <= tx_en_d;
      done_q    <= done_d;
    end
  end

  assign pulse_p = pulse_p_q;
  assign pulse_n = pulse_n_q;
  assign clamp   = clamp_q;
  assign tx_en   = tx_en_q;
  assign busy    = tx_en_q;
  assign done    = done_q;

endmodule
